lane_unpack: RTL and testbench
==============================

Name: lane_unpack

Overview:
- Reader-side counterpart of the lane-granular register write path.
- Accepts one LANES*N-bit word plus a lane mask through a valid/ready handshake.
- Emits the enabled lanes one per handshake, in ascending lane index, on an N-bit lane stream. Lanes whose mask bit is clear are skipped.
- Sits between a wide register or datapath and a narrow lane-serial consumer.

Parameters:
- N, 4, lane width in bits.
- LANES, 4, lanes per word; IDXW = max(1, $clog2(LANES)).

Ports:
- clk  input  1  clock, all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- IN_valid  input  1  word offered by the upstream side.
- IN_dat  input  LANES*N  word; lane k is IN_dat[k*N +: N].
- IN_mask  input  LANES  lane enables; bit k set means lane k is emitted.
- OUT_ready  output  1  block accepts a word this cycle.
- OUT_valid  output  1  lane output is valid.
- OUT_lane  output  N  current lane data.
- OUT_idx  output  IDXW  index of the current lane.
- OUT_last  output  1  current lane is the final enabled lane of the word.
- IN_ready  input  1  downstream consumes the lane when OUT_valid is also high.
- OUT_busy  output  1  a word is held and lanes remain to be emitted.

Behaviour:
- Reset (rst high, asynchronous), held while rst is high:
  - state = IDLE; data register = 0; remaining-mask register = 0.
  - OUT_valid = 0, OUT_lane = 0, OUT_idx = 0, OUT_last = 0, OUT_busy = 0.
  - OUT_ready = 0 while rst is high, then 1 from the first cycle after release.
- State IDLE:
  - OUT_ready = 1, OUT_valid = 0.
  - On IN_valid: capture IN_dat and set rem = IN_mask.
  - If IN_mask != 0, go to EMIT.
  - If IN_mask == 0, the word is accepted and discarded: stay in IDLE, no lane is emitted.
- State EMIT:
  - OUT_valid = 1 and OUT_busy = 1.
  - OUT_idx = index of the lowest set bit of rem.
  - OUT_lane = captured lane at OUT_idx.
  - OUT_last = 1 when rem has exactly one set bit.
  - OUT_lane, OUT_idx and OUT_last are stable while OUT_valid && !IN_ready.
- Lane handshake (OUT_valid && IN_ready):
  - Clear bit OUT_idx in rem.
  - If OUT_last: return to IDLE, unless a new word is accepted in the same cycle (see below).
- OUT_ready = IDLE || (OUT_valid && IN_ready && OUT_last). This is a combinational path from IN_ready.
- Back-to-back words: if the final-lane handshake and IN_valid occur in the same cycle, the new word is captured that cycle.
  - If its mask is nonzero, stay in EMIT: OUT_valid stays high with no bubble.
  - If its mask is zero, go to IDLE.
- Latency: a word accepted in cycle t presents its first lane in cycle t+1. With IN_ready held high, k enabled lanes take exactly k cycles.
- IN_dat and IN_mask are sampled only on an accept. Changes at any other time have no effect.
- Reset asserted mid-word: the remaining lanes are dropped, and the block returns to the IDLE reset values immediately.
- rem never has bits set beyond LANES-1.

Test Plan:
- Single word, N=4: IN_dat=16'hDCBA, IN_mask=4'b1111, IN_ready=1 -> lanes A,B,C,D with idx 0,1,2,3 in 4 consecutive cycles; OUT_last only on D; OUT_ready high in the D cycle.
- Sparse mask: IN_dat=16'h4321, IN_mask=4'b1010 -> lane 2 (idx 1) then lane 4 (idx 3, last); lanes 1 and 3 are never shown.
- Backpressure: mask 4'b0111, IN_ready toggling 1,0,0,1,1 -> each lane is held stable while stalled; exactly 3 handshakes total; no lane is duplicated or lost.
- Back-to-back: word0 mask 4'b1000, word1 16'h00F0 mask 4'b0010 offered during word0's last cycle -> OUT_valid stays high; the next cycle shows lane F at idx 1 with OUT_last=1.
- Zero mask: IN_valid with mask 0 in IDLE -> accepted (OUT_ready=1); OUT_valid stays 0; the next word is accepted the following cycle.
- Async reset mid-word: mask 4'b1111, assert rst after the 2nd handshake, between clock edges -> OUT_valid and OUT_busy drop immediately; after release OUT_ready=1 and no stale lanes appear.

Source files
------------

// File: rtl/lane_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : lane_unpack
//  Purpose  : Reader-side lane serialiser. Accepts one LANES*N-bit word plus
//             a lane-enable mask over a valid/ready handshake and replays the
//             enabled lanes, lowest index first, on an N-bit lane stream.
//             Lanes whose mask bit is clear are skipped entirely.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             IN_valid      - upstream offers a word
//             IN_dat        - word, lane k at IN_dat[k*N +: N]
//             IN_mask       - lane enables, bit k => lane k emitted
//             OUT_ready     - word accepted this cycle when IN_valid is high
//             OUT_valid     - lane output valid
//             OUT_lane      - current lane data
//             OUT_idx       - index of current lane
//             OUT_last      - current lane is the last enabled lane of word
//             IN_ready      - downstream consumes lane when OUT_valid high
//             OUT_busy      - a word is held with lanes still to emit
//  Revision : 1.0 - initial release
// ============================================================================
module lane_unpack #(
    parameter int N     = 4,
    parameter int LANES = 4,
    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IN_valid,
    input  logic [LANES*N-1:0]   IN_dat,
    input  logic [LANES-1:0]     IN_mask,
    output logic                 OUT_ready,
    output logic                 OUT_valid,
    output logic [N-1:0]         OUT_lane,
    output logic [IDXW-1:0]      OUT_idx,
    output logic                 OUT_last,
    input  logic                 IN_ready,
    output logic                 OUT_busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LANES*N-1:0]     r_data;
    logic [LANES-1:0]       r_rem;

    logic [IDXW-1:0]        w_idx;
    logic [LANES-1:0]       w_idx_onehot;
    logic                   w_single;
    logic                   w_emit;
    logic                   w_lane_hs;
    logic                   w_done;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_mask_nz;

    // Lowest set bit of the remaining mask: scan downwards so the final
    // assignment wins with the smallest index.
    always_comb begin
        w_idx = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (r_rem[k]) begin
                w_idx = IDXW'(k);
            end
        end
    end

    assign w_idx_onehot = LANES'(1) << w_idx;
    // Exactly one bit left (only meaningful while emitting, where rem != 0).
    assign w_single     = ((r_rem & (r_rem - LANES'(1))) == '0);
    assign w_emit       = (r_state == S_EMIT);
    assign w_lane_hs    = w_emit && IN_ready;
    assign w_done       = w_lane_hs && w_single;
    // Combinational from IN_ready so a new word can be taken on the cycle the
    // final lane leaves, giving bubble-free back-to-back words.
    assign w_ready      = !rst && (!w_emit || w_done);
    assign w_accept     = w_ready && IN_valid;
    assign w_mask_nz    = (IN_mask != '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_mask_nz) begin
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_done) begin
                    w_state_next = (w_accept && w_mask_nz) ? S_EMIT : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_next;
            // A fresh word overrides the clear of the final lane bit.
            if (w_accept) begin
                r_data <= IN_dat;
                r_rem  <= IN_mask;
            end else if (w_lane_hs) begin
                r_rem  <= r_rem & ~w_idx_onehot;
            end
        end
    end

    assign OUT_ready = w_ready;
    assign OUT_valid = w_emit;
    assign OUT_busy  = w_emit;
    assign OUT_last  = w_emit && w_single;
    assign OUT_idx   = w_emit ? w_idx : '0;
    assign OUT_lane  = w_emit ? r_data[w_idx*N +: N] : '0;

endmodule
`default_nettype wire

// File: tb/tb_lane_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lane_unpack
//  Purpose  : Self-checking bench for lane_unpack. A queue of pending lanes
//             models the block: each accepted word pushes its enabled lanes
//             in ascending order, each lane handshake pops the head.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lane_unpack;

    localparam int N     = 4;
    localparam int LANES = 4;
    localparam int IDXW  = 2;
    localparam int VW    = 4 + IDXW + N;

    logic                clk      = 1'b0;
    logic                rst      = 1'b1;
    logic                in_valid = 1'b0;
    logic [LANES*N-1:0]  in_dat   = '0;
    logic [LANES-1:0]    in_mask  = '0;
    logic                in_ready = 1'b0;
    logic                out_ready;
    logic                out_valid;
    logic [N-1:0]        out_lane;
    logic [IDXW-1:0]     out_idx;
    logic                out_last;
    logic                out_busy;

    int compared   = 0;
    int mismatched = 0;

    lane_unpack #(.N(N), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .IN_valid  (in_valid),
        .IN_dat    (in_dat),
        .IN_mask   (in_mask),
        .OUT_ready (out_ready),
        .OUT_valid (out_valid),
        .OUT_lane  (out_lane),
        .OUT_idx   (out_idx),
        .OUT_last  (out_last),
        .IN_ready  (in_ready),
        .OUT_busy  (out_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [N-1:0]    dat;
    } lane_t;

    lane_t q[$];

    wire [VW-1:0] obs = {out_valid, out_ready, out_last, out_busy, out_idx, out_lane};

    // Expected output vector from the pending-lane queue.
    function automatic logic [VW-1:0] exp_out();
        logic  v, l, rd;
        lane_t h;
        if (rst) return '0;
        v  = (q.size() != 0);
        l  = (q.size() == 1);
        rd = !v || (in_ready && l);
        h  = v ? q[0] : '0;
        return {v, rd, l, v, h.idx, h.dat};
    endfunction

    task automatic model_clock();
        bit    rd;
        lane_t e;
        if (rst) begin
            q.delete();
            return;
        end
        rd = (q.size() == 0) || (in_ready && q.size() == 1);
        if (q.size() != 0 && in_ready) void'(q.pop_front());
        if (rd && in_valid) begin
            for (int k = 0; k < LANES; k++) begin
                if (in_mask[k]) begin
                    e.idx = k[IDXW-1:0];
                    e.dat = in_dat[k*N +: N];
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic [LANES*N-1:0] d,
                         input logic [LANES-1:0] m, input logic r);
        in_valid = v;
        in_dat   = d;
        in_mask  = m;
        in_ready = r;
        @(negedge clk);
    endtask

    task automatic advance();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared++;
        if (obs !== exp_out()) begin
            mismatched++;
            $display("FAIL reset_hold: observed %h expected %h", obs, exp_out());
        end
        compared++;
        if (out_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ready: observed %b expected 0", out_ready);
        end
        model_clock();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (obs !== exp_out()) begin
            mismatched++;
            $display("FAIL reset_release: observed %h expected %h", obs, exp_out());
        end
        advance();
    endtask

    task automatic test_full_word();
        for (int i = 0; i < 6; i++) begin
            drive(i == 0, (i == 0) ? 16'hDCBA : 16'($urandom),
                  (i == 0) ? 4'hF : 4'($urandom), 1'b1);
            compared++;
            if (obs !== exp_out()) begin
                mismatched++;
                $display("FAIL full_word c%0d: observed %h expected %h", i, obs, exp_out());
            end
            if (i == 4) begin
                compared++;
                if ({out_ready, out_last, out_lane, out_idx} !== {1'b1, 1'b1, 4'hD, 2'd3}) begin
                    mismatched++;
                    $display("FAIL full_word_last: observed rdy=%b last=%b lane=%h idx=%0d expected 1 1 d 3",
                             out_ready, out_last, out_lane, out_idx);
                end
            end
            advance();
        end
    endtask

    task automatic test_sparse();
        logic [N-1:0] seen[$];
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, (i == 0) ? 16'h4321 : 16'($urandom),
                  (i == 0) ? 4'b1010 : 4'($urandom), 1'b1);
            compared++;
            if (obs !== exp_out()) begin
                mismatched++;
                $display("FAIL sparse c%0d: observed %h expected %h", i, obs, exp_out());
            end
            if (out_valid && in_ready) seen.push_back(out_lane);
            advance();
        end
        compared++;
        if (seen.size() != 2 || seen[0] !== 4'h2 || seen[1] !== 4'h4) begin
            mismatched++;
            $display("FAIL sparse_seq: observed %0d lanes (first %h) expected lanes 2,4",
                     seen.size(), (seen.size() != 0) ? seen[0] : 4'h0);
        end
    endtask

    task automatic test_backpressure();
        logic rdy[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int   hs = 0;
        for (int i = 0; i < 7; i++) begin
            drive(i == 0, 16'($urandom), (i == 0) ? 4'b0111 : 4'($urandom), rdy[i]);
            compared++;
            if (obs !== exp_out()) begin
                mismatched++;
                $display("FAIL backpressure c%0d: observed %h expected %h", i, obs, exp_out());
            end
            if (out_valid && in_ready) hs++;
            advance();
        end
        compared++;
        if (hs != 3) begin
            mismatched++;
            $display("FAIL backpressure_count: observed %0d handshakes expected 3", hs);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(1'b1, 16'($urandom), 4'b1000, 1'b1);
                1:       drive(1'b1, 16'h00F0, 4'b0010, 1'b1);
                default: drive(1'b0, 16'($urandom), 4'($urandom), 1'b1);
            endcase
            compared++;
            if (obs !== exp_out()) begin
                mismatched++;
                $display("FAIL back_to_back c%0d: observed %h expected %h", i, obs, exp_out());
            end
            if (i == 2) begin
                compared++;
                if ({out_valid, out_lane, out_idx, out_last} !== {1'b1, 4'hF, 2'd1, 1'b1}) begin
                    mismatched++;
                    $display("FAIL back_to_back_word1: observed v=%b lane=%h idx=%0d last=%b expected 1 f 1 1",
                             out_valid, out_lane, out_idx, out_last);
                end
            end
            advance();
        end
    endtask

    task automatic test_zero_mask();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(1'b1, 16'($urandom), 4'b0000, 1'b1);
                1:       drive(1'b1, 16'($urandom), 4'b0100, 1'b1);
                default: drive(1'b0, 16'($urandom), 4'($urandom), 1'b1);
            endcase
            compared++;
            if (obs !== exp_out()) begin
                mismatched++;
                $display("FAIL zero_mask c%0d: observed %h expected %h", i, obs, exp_out());
            end
            if (i < 2) begin
                compared++;
                if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
                    mismatched++;
                    $display("FAIL zero_mask_idle c%0d: observed rdy=%b v=%b expected 1 0",
                             i, out_ready, out_valid);
                end
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, 16'($urandom), (i == 0) ? 4'hF : 4'($urandom), 1'b1);
            compared++;
            if (obs !== exp_out()) begin
                mismatched++;
                $display("FAIL async_pre c%0d: observed %h expected %h", i, obs, exp_out());
            end
            advance();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0 || out_busy !== 1'b0 || obs !== '0) begin
            mismatched++;
            $display("FAIL async_drop: observed %h expected 0", obs);
        end
        @(negedge clk);
        advance();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'($urandom), 4'($urandom), 1'b1);
            compared++;
            if (obs !== exp_out()) begin
                mismatched++;
                $display("FAIL async_post c%0d: observed %h expected %h", i, obs, exp_out());
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [LANES-1:0] m;
        for (int i = 0; i < 400; i++) begin
            m = 4'($urandom);
            if ($urandom_range(0, 7) == 0) m = '0;
            drive(($urandom_range(0, 99) < 60) && (i < 390), 16'($urandom), m,
                  ($urandom_range(0, 99) < 70) || (i >= 390));
            compared++;
            if (obs !== exp_out()) begin
                mismatched++;
                $display("FAIL random c%0d: observed %h expected %h", i, obs, exp_out());
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_sparse();
        test_backpressure();
        test_back_to_back();
        test_zero_mask();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
